// File: rtl/muldiv_sequencer.sv
// Multicycle signed mult/div sequencer for the HI/LO path (Booth radix-2 multiply, restoring divide).
// Optional unsigned multu/divu support is enabled by defining MULDIV_UNSIGNED_EN.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             flush,
`ifdef MULDIV_UNSIGNED_EN
  input  logic             op_unsigned,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             hi_write,
  output logic             lo_write,
  output logic             hilo_sel,
  output logic             divz
);

  typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_DONE, S_DZ} state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             q1_q, q1_d;
  logic             uns_q, uns_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_out_q, hi_out_d;
  logic [WIDTH-1:0] lo_out_q, lo_out_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             hi_write_q, hi_write_d, lo_write_q, lo_write_d;
  logic             hilo_sel_q, hilo_sel_d, divz_q, divz_d;

  logic             start_uns;
`ifdef MULDIV_UNSIGNED_EN
  assign start_uns = op_unsigned;
`else
  assign start_uns = 1'b0;
`endif

  // Operand magnitudes for the divider; |-2^(W-1)| wraps to the unsigned value 2^(W-1)
  logic [WIDTH-1:0] abs_a, abs_b;
  assign abs_a = (op_a[WIDTH-1] && !start_uns) ? (-op_a) : op_a;
  assign abs_b = (op_b[WIDTH-1] && !start_uns) ? (-op_b) : op_b;

  // One multiply step: Booth (signed) or shift-add (unsigned) on a W+1 bit upper accumulator
  logic [WIDTH:0]   mcand_ext, booth_sum, mul_hi;
  logic [WIDTH-1:0] mul_lo;
  always_comb begin
    mcand_ext = uns_q ? {1'b0, mcand_q} : {mcand_q[WIDTH-1], mcand_q};
    booth_sum = acc_hi_q;
    if (uns_q) begin
      if (acc_lo_q[0]) booth_sum = acc_hi_q + mcand_ext;
    end else if (acc_lo_q[0] && !q1_q) begin
      booth_sum = acc_hi_q - mcand_ext;
    end else if (!acc_lo_q[0] && q1_q) begin
      booth_sum = acc_hi_q + mcand_ext;
    end
    mul_hi = {(uns_q ? 1'b0 : booth_sum[WIDTH]), booth_sum[WIDTH:1]};
    mul_lo = {booth_sum[0], acc_lo_q[WIDTH-1:1]};
  end

  // One restoring divide step; remainder in acc_hi, dividend shifting out of acc_lo as quotient shifts in
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff, div_rem, div_quo, fix_quo, fix_rem;
  always_comb begin
    div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mcand_q};
    div_diff  = div_shift[WIDTH-1:0] - mcand_q;
    div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_quo   = {acc_lo_q[WIDTH-2:0], div_ge};
    fix_quo   = neg_q_q ? (-div_quo) : div_quo;
    fix_rem   = neg_r_q ? (-div_rem) : div_rem;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      mcand_q    <= '0;
      q1_q       <= 1'b0;
      uns_q      <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      cnt_q      <= '0;
      hi_out_q   <= '0;
      lo_out_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_write_q <= 1'b0;
      lo_write_q <= 1'b0;
      hilo_sel_q <= 1'b0;
      divz_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      mcand_q    <= mcand_d;
      q1_q       <= q1_d;
      uns_q      <= uns_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      cnt_q      <= cnt_d;
      hi_out_q   <= hi_out_d;
      lo_out_q   <= lo_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hi_write_q <= hi_write_d;
      lo_write_q <= lo_write_d;
      hilo_sel_q <= hilo_sel_d;
      divz_q     <= divz_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    mcand_d    = mcand_q;
    q1_d       = q1_q;
    uns_d      = uns_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    cnt_d      = cnt_q;
    hi_out_d   = hi_out_q;
    lo_out_d   = lo_out_q;
    hilo_sel_d = hilo_sel_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_mult) begin
          state_d    = S_MULT;
          acc_hi_d   = '0;
          acc_lo_d   = op_b;
          mcand_d    = op_a;
          q1_d       = 1'b0;
          uns_d      = start_uns;
          cnt_d      = '0;
          hilo_sel_d = 1'b0;
        end else if (start_div) begin
          hilo_sel_d = 1'b1;
          if (op_b == '0) begin
            state_d = S_DZ;
          end else begin
            state_d  = S_DIV;
            acc_hi_d = '0;
            acc_lo_d = abs_a;
            mcand_d  = abs_b;
            uns_d    = start_uns;
            neg_q_d  = !start_uns && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            neg_r_d  = !start_uns && op_a[WIDTH-1];
            cnt_d    = '0;
          end
        end
      end
      S_MULT: begin
        acc_hi_d = mul_hi;
        acc_lo_d = mul_lo;
        q1_d     = acc_lo_q[0];
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = S_DONE;
          hi_out_d = mul_hi[WIDTH-1:0];
          lo_out_d = mul_lo;
        end
      end
      S_DIV: begin
        acc_hi_d = {1'b0, div_rem};
        acc_lo_d = div_quo;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = S_DONE;
          hi_out_d = fix_rem;
          lo_out_d = fix_quo;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_DZ:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over completion and over a fresh start; committed results are kept
    if (flush) begin
      state_d    = S_IDLE;
      hi_out_d   = hi_out_q;
      lo_out_d   = lo_out_q;
      hilo_sel_d = hilo_sel_q;
    end

    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE) || (state_d == S_DZ);
    hi_write_d = (state_d == S_DONE);
    lo_write_d = (state_d == S_DONE);
    divz_d     = (state_d == S_DZ);
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi_out   = hi_out_q;
  assign lo_out   = lo_out_q;
  assign hi_write = hi_write_q;
  assign lo_write = lo_write_q;
  assign hilo_sel = hilo_sel_q;
  assign divz     = divz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: expected results are queued at start and checked at done.
module tb_muldiv_sequencer;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        sel;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult, start_div, flush;
  logic [31:0] op_a, op_b;
  logic        busy, done, hi_write, lo_write, hilo_sel, divz;
  logic [31:0] hi_out, lo_out;
`ifdef MULDIV_UNSIGNED_EN
  logic        op_unsigned;
`endif

  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .flush      (flush),
`ifdef MULDIV_UNSIGNED_EN
    .op_unsigned(op_unsigned),
`endif
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .hi_write   (hi_write),
    .lo_write   (lo_write),
    .hilo_sel   (hilo_sel),
    .divz       (divz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference arithmetic in 64 bits so the -2^31/-1 case needs no special handling
  function automatic exp_t model(input logic m, input logic [31:0] a, input logic [31:0] b,
                                 input logic uns);
    exp_t e;
    logic signed [63:0] sa, sb, sp;
    logic [63:0] up;
    e.dz  = 1'b0;
    e.sel = !m;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    if (m) begin
      if (uns) up = {32'b0, a} * {32'b0, b};
      else begin sp = sa * sb; up = sp; end
      e.hi = up[63:32];
      e.lo = up[31:0];
    end else if (b == 32'd0) begin
      e.dz = 1'b1;
      e.hi = last_hi;
      e.lo = last_lo;
    end else if (uns) begin
      e.lo = a / b;
      e.hi = a % b;
    end else begin
      sp = sa / sb;
      e.lo = sp[31:0];
      sp = sa % sb;
      e.hi = sp[31:0];
    end
    return e;
  endfunction

  // Issue one operation, optionally poke start_div mid-flight, then check latency and result
  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic uns, input int inj_cyc);
    exp_t e;
    int   cyc;
    int   lat;
    logic gap;
    e = model(m, a, b, uns);
    lat = e.dz ? 1 : 33;
    sb_q.push_back(e);
    if (!e.dz) begin last_hi = e.hi; last_lo = e.lo; end
    @(negedge clk);
    start_mult = m; start_div = d; op_a = a; op_b = b;
`ifdef MULDIV_UNSIGNED_EN
    op_unsigned = uns;
`endif
    @(negedge clk);
    cyc = 1;
    start_mult = 1'b0; start_div = 1'b0;
    check("busy_c1", 32'(busy), 32'd1);
    op_a = $urandom; op_b = $urandom;
    gap = 1'b0;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (busy !== 1'b1) gap = 1'b1;
      if (cyc == inj_cyc) begin start_div = 1'b1; op_b = 32'd5; end
      if (cyc == inj_cyc + 1) start_div = 1'b0;
    end
    check("latency", 32'(cyc), 32'(lat));
    check("busy_hold", 32'(gap), 32'd0);
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("hi_out", hi_out, e.hi);
      check("lo_out", lo_out, e.lo);
      check("divz", 32'(divz), 32'(e.dz));
      check("hi_write", 32'(hi_write), 32'(!e.dz));
      check("lo_write", 32'(lo_write), 32'(!e.dz));
      check("hilo_sel", 32'(hilo_sel), 32'(e.sel));
    end
    @(negedge clk);
    check("busy_after", 32'(busy), 32'd0);
    check("done_after", 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start_mult = 1'b0; start_div = 1'b0; flush = 1'b0;
    op_a = '0; op_b = '0;
`ifdef MULDIV_UNSIGNED_EN
    op_unsigned = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    check("rst_sel", 32'(hilo_sel), 32'd0);
    reset = 1'b1;

    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, 0);
    check("t1_hi_const", hi_out, 32'hFFFF_FFFF);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    check("t3_lo_const", lo_out, 32'h8000_0000);
    run_op(1'b0, 1'b1, 32'd1234, 32'd0, 1'b0, 0);
    run_op(1'b1, 1'b1, 32'd9, 32'd4, 1'b0, 0);
    run_op(1'b1, 1'b0, 32'd100, 32'hFFFF_FF00, 1'b0, 10);
    run_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 1'b0, 0);
    run_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, 1'b0, $urandom, $urandom, 1'b0, 0);
      run_op(1'b0, 1'b1, $urandom, $urandom_range(1, 32'h7FFF_FFFF), 1'b0, 0);
    end
`ifdef MULDIV_UNSIGNED_EN
    run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1, 0);
    check("u_lo_const", lo_out, 32'h7FFF_FFFF);
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
`endif

    // Asynchronous reset in cycle 15 of a divide
    @(negedge clk);
    start_div = 1'b1; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    start_div = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_hi", hi_out, 32'd0);
    check("arst_lo", lo_out, 32'd0);
    check("arst_sel", 32'(hilo_sel), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    last_hi = '0; last_lo = '0;

    // Flush in cycle 32 of a multiply
    @(negedge clk);
    start_mult = 1'b1; op_a = 32'd3; op_b = 32'd5;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (31) @(negedge clk);
    check("fl_busy32", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_done", 32'(done), 32'd0);
    check("fl_hiw", 32'(hi_write), 32'd0);
    check("fl_low", 32'(lo_write), 32'd0);
    check("fl_busy", 32'(busy), 32'd0);
    check("fl_hi", hi_out, last_hi);
    check("fl_lo", lo_out, last_lo);
    repeat (3) @(negedge clk);
    check("fl_quiet", 32'(done), 32'd0);

    run_op(1'b1, 1'b0, 32'd3, 32'd5, 1'b0, 0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multicycle mult/div controller for the CPU core's HI/LO path.
- Accepts a mult or div request from the control unit and latches the A/B operands.
- Runs an iterative signed Booth-radix-2 multiply or signed restoring divide, one step per clock.
- Drives HI/LO write strobes plus a divide-by-zero exception flag, and holds `busy` so the control FSM stalls until `done`.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_mult  input  1  request signed multiply; sampled only in IDLE.
- start_div  input  1  request signed divide; sampled only in IDLE.
- flush  input  1  synchronous abort (exception in progress).
- op_a  input  WIDTH  multiplicand / dividend (register A).
- op_b  input  WIDTH  multiplier / divisor (register B).
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- hi_out  output  WIDTH  HI result (mult upper word / div remainder).
- lo_out  output  WIDTH  LO result (mult lower word / div quotient).
- hi_write  output  1  HI register write enable.
- lo_write  output  1  LO register write enable.
- hilo_sel  output  1  HI/LO mux select: 0 = mult, 1 = div; valid while busy or done.
- divz  output  1  divide-by-zero pulse, concurrent with done.

Behaviour:
- Reset (reset = 0, async): state IDLE. busy, done, hi_write, lo_write, divz, hilo_sel = 0. hi_out, lo_out, counter and internal accumulators = 0.
- States: IDLE, MULT, DIV, DONE, DZ.
- IDLE:
  - start_mult = 1 → latch op_a/op_b, go to MULT, counter = 0, hilo_sel = 0.
  - else start_div = 1 and op_b != 0 → latch operands, go to DIV, hilo_sel = 1.
  - start_div = 1 and op_b == 0 → go to DZ.
  - Both starts high together: mult wins; div is dropped.
- MULT: one Booth step per cycle on a {HI, LO, q-1} accumulator with arithmetic right shift. After WIDTH steps → DONE.
- DIV:
  - Restoring division on operand magnitudes: |x| of −2^(WIDTH−1) is taken as unsigned 2^(WIDTH−1). WIDTH steps.
  - Sign fix-up applies combinationally on entry to DONE:
    - quotient negated iff operand signs differ;
    - remainder takes the dividend's sign.
  - −2^31 / −1 yields LO = 0x80000000, HI = 0; no exception.
- DONE (exactly one cycle): done = hi_write = lo_write = 1. hi_out/lo_out carry the final result, then → IDLE.
- DZ (exactly one cycle): done = divz = 1; hi_write = lo_write = 0; hi_out/lo_out unchanged; → IDLE.
- Latency: start high in cycle 0 → done in cycle WIDTH+1 (cycle 33 for 32). Divide by zero → done in cycle 1.
- busy = 1 in MULT, DIV, DONE and DZ; 0 in IDLE.
- Starts while busy are ignored; they are not queued.
- hi_out/lo_out hold their last committed values between operations.
- flush = 1 in any state → IDLE next edge; no writes, no done, outputs hold. flush has priority over DONE/DZ and over a start in IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs 0.
- Operand changes after the start edge have no effect.

Optional Feature:
- Macro: MULDIV_UNSIGNED_EN.
- Defined:
  - Adds input op_unsigned (1 bit), latched with start.
  - When 1, the operation is multu/divu: no Booth sign handling; divide uses raw operands with no sign fix-up.
  - Latency is unchanged.
- Undefined: port absent; all operations signed.

Test Plan:
1. Multiply: start_mult with op_a = 7, op_b = 0xFFFFFFFD (−3) → busy cycles 1–33; done, hi_write, lo_write in cycle 33 only; hi_out = 0xFFFFFFFF, lo_out = 0xFFFFFFEB.
2. Multiply corner: op_a = op_b = 0x80000000 → hi_out = 0x40000000, lo_out = 0x00000000. Then 0xFFFFFFFF × 0xFFFFFFFF → hi_out = 0, lo_out = 1.
3. Signed divide: start_div with op_a = 0xFFFFFFF9 (−7), op_b = 2 → lo_out = 0xFFFFFFFD, hi_out = 0xFFFFFFFF, done in cycle 33. Then 0x80000000 / 0xFFFFFFFF → lo_out = 0x80000000, hi_out = 0.
4. Divide by zero: start_div with op_b = 0 → cycle 1: done = divz = 1, hi_write = lo_write = 0, hi_out/lo_out keep prior values; busy = 0 in cycle 2.
5. Start arbitration: start_mult and start_div both high in cycle 0 → mult result only (hilo_sel = 0). start_div pulsed in cycle 10 of a mult → ignored; single done in cycle 33.
6. Aborts: reset low in cycle 15 of a div → busy and all outputs 0 immediately. Separately, flush in cycle 32 of a mult → IDLE in cycle 33 with no done and no writes.
7. With MULDIV_UNSIGNED_EN defined: op_unsigned = 1, 0xFFFFFFFF / 2 → lo_out = 0x7FFFFFFF, hi_out = 1.
